// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM encoding, parity modes, oversampling.
package uart_pkg;

  localparam int OSR = 16;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_STOP    = 3'd4;
  localparam logic [2:0] ST_RECOVER = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    START   = ST_START,
    DATA    = ST_DATA,
    PARITY  = ST_PARITY,
    STOP    = ST_STOP,
    RECOVER = ST_RECOVER
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reset value is selectable.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: LSB-first DBIT data, optional parity, SB_TICK-long stop period.
//
// state   | meaning
// IDLE    | line high, watching rx_s every clk for a falling edge
// START   | counting to mid start bit, rejecting glitches
// DATA    | sampling DBIT data bits at mid-bit
// PARITY  | sampling the parity bit and computing the mismatch
// STOP    | waiting to the stop sample point, then publishing the word
// RECOVER | line still low after stop (break); wait for it to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            parity_en,
  input  logic            parity_odd,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            busy
);

  localparam logic [4:0] MID_CNT  = 5'(OSR / 2 - 1);
  localparam logic [4:0] BIT_CNT  = 5'(OSR - 1);
  localparam logic [4:0] STOP_CNT = 5'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT = 3'(DBIT - 1);

  rx_state_t       state;
  logic            rx_s;
  logic [4:0]      s_cnt;
  logic [2:0]      n_cnt;
  logic [DBIT-1:0] b_reg;
  logic            p_reg;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      b_reg        <= '0;
      p_reg        <= 1'b0;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
            s_cnt <= '0;
            p_reg <= 1'b0;
          end
        end

        START: begin
          if (s_tick) begin
            if (s_cnt == MID_CNT) begin
              if (!rx_s) begin
                state <= DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s_cnt == BIT_CNT) begin
              s_cnt <= '0;
              b_reg <= {rx_s, b_reg[DBIT-1:1]};
              if (n_cnt == LAST_BIT) begin
                state <= parity_en ? PARITY : STOP;
              end else begin
                n_cnt <= n_cnt + 3'd1;
              end
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end

        PARITY: begin
          if (s_tick) begin
            if (s_cnt == BIT_CNT) begin
              // Data XOR parity bit is 0 for even parity, 1 for odd.
              p_reg <= ((^b_reg) ^ rx_s) != parity_odd;
              s_cnt <= '0;
              state <= STOP;
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end

        STOP: begin
          if (s_tick) begin
            if (s_cnt == STOP_CNT) begin
              rx_dout      <= b_reg;
              parity_err   <= p_reg & parity_en;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
              s_cnt        <= '0;
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= RECOVER;
              end
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end

        RECOVER: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
